// File: rtl/kb_pkg.sv
// kb_pkg: shared Set 2 scancode, ASCII constants and prefix FSM encoding.
package kb_pkg;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [6:0] ASCII_CR  = 7'd13;
    localparam logic [6:0] ASCII_BS  = 7'd8;
    localparam logic [6:0] ASCII_SP  = 7'd32;
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
endpackage

// File: rtl/scancode_to_ascii.sv
// scancode_to_ascii: combinational Set 2 make-code to 7-bit ASCII lookup.
module scancode_to_ascii
    import kb_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [6:0] ascii,
    output logic       hit
);
    logic [6:0] low, up;
    logic       letter;
    always_comb begin
        letter = 1'b0;
        low    = '0;
        up     = '0;
        hit    = 1'b1;
        case (code)
            8'h1C: {letter, low} = {1'b1, 7'h61};
            8'h32: {letter, low} = {1'b1, 7'h62};
            8'h21: {letter, low} = {1'b1, 7'h63};
            8'h23: {letter, low} = {1'b1, 7'h64};
            8'h24: {letter, low} = {1'b1, 7'h65};
            8'h2B: {letter, low} = {1'b1, 7'h66};
            8'h34: {letter, low} = {1'b1, 7'h67};
            8'h33: {letter, low} = {1'b1, 7'h68};
            8'h43: {letter, low} = {1'b1, 7'h69};
            8'h3B: {letter, low} = {1'b1, 7'h6A};
            8'h42: {letter, low} = {1'b1, 7'h6B};
            8'h4B: {letter, low} = {1'b1, 7'h6C};
            8'h3A: {letter, low} = {1'b1, 7'h6D};
            8'h31: {letter, low} = {1'b1, 7'h6E};
            8'h44: {letter, low} = {1'b1, 7'h6F};
            8'h4D: {letter, low} = {1'b1, 7'h70};
            8'h15: {letter, low} = {1'b1, 7'h71};
            8'h2D: {letter, low} = {1'b1, 7'h72};
            8'h1B: {letter, low} = {1'b1, 7'h73};
            8'h2C: {letter, low} = {1'b1, 7'h74};
            8'h3C: {letter, low} = {1'b1, 7'h75};
            8'h2A: {letter, low} = {1'b1, 7'h76};
            8'h1D: {letter, low} = {1'b1, 7'h77};
            8'h22: {letter, low} = {1'b1, 7'h78};
            8'h35: {letter, low} = {1'b1, 7'h79};
            8'h1A: {letter, low} = {1'b1, 7'h7A};
            8'h16: {low, up} = {7'h31, 7'h21};
            8'h1E: {low, up} = {7'h32, 7'h40};
            8'h26: {low, up} = {7'h33, 7'h23};
            8'h25: {low, up} = {7'h34, 7'h24};
            8'h2E: {low, up} = {7'h35, 7'h25};
            8'h36: {low, up} = {7'h36, 7'h5E};
            8'h3D: {low, up} = {7'h37, 7'h26};
            8'h3E: {low, up} = {7'h38, 7'h2A};
            8'h46: {low, up} = {7'h39, 7'h28};
            8'h45: {low, up} = {7'h30, 7'h29};
            8'h4E: {low, up} = {7'h2D, 7'h5F};
            8'h55: {low, up} = {7'h3D, 7'h2B};
            8'h41: {low, up} = {7'h2C, 7'h3C};
            8'h49: {low, up} = {7'h2E, 7'h3E};
            8'h4A: {low, up} = {7'h2F, 7'h3F};
            8'h29: {low, up} = {ASCII_SP, ASCII_SP};
            8'h5A: {low, up} = {ASCII_CR, ASCII_CR};
            8'h66: {low, up} = {ASCII_BS, ASCII_BS};
            default: hit = 1'b0;
        endcase
        ascii = !hit ? 7'd0 : letter ? ((shift ^ caps) ? low - 7'd32 : low) : (shift ? up : low);
    end
endmodule

// File: rtl/ps2_ascii_source.sv
// ps2_ascii_source: Set 2 scancode bytes to paced single-cycle ASCII pulses.
// Prefix FSM and modifiers feed a lookup; characters queue in a FIFO drained every RELEASE_GAP cycles.
module ps2_ascii_source
    import kb_pkg::*;
#(
    parameter int                 FIFO_DEPTH  = 4,
    parameter int                 GAP_W       = 24,
    parameter logic [GAP_W-1:0]   RELEASE_GAP = 24'd8388608
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] scan_byte,
    input  logic       scan_valid,
    output logic [6:0] ascii,
    output logic       asciiready,
    output logic       caps,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    state_t           state, state_nxt;
    logic             make, brk;
    logic             lshift, rshift, caps_held;
    logic [6:0]       map_ascii;
    logic             map_hit;
    logic [6:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic [GAP_W-1:0] gap;
    logic             full, push, do_push, pop;

    scancode_to_ascii u_map (
        .code  (scan_byte),
        .shift (lshift | rshift),
        .caps  (caps),
        .ascii (map_ascii),
        .hit   (map_hit)
    );

    always_comb begin
        state_nxt = state;
        make      = 1'b0;
        brk       = 1'b0;
        if (scan_valid) begin
            case (state)
                IDLE: begin
                    state_nxt = scan_byte == SC_EXT ? EXT : scan_byte == SC_BRK ? BRK : IDLE;
                    make      = scan_byte != SC_EXT && scan_byte != SC_BRK;
                end
                BRK: begin
                    state_nxt = IDLE;
                    brk       = 1'b1;
                end
                EXT:     state_nxt = scan_byte == SC_BRK ? EXT_BRK : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Full is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
    assign full    = cnt == CW'(FIFO_DEPTH);
    assign push    = make && map_hit;
    assign do_push = push && !full;
    assign pop     = gap == '0 && cnt != '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            lshift     <= 1'b0;
            rshift     <= 1'b0;
            caps_held  <= 1'b0;
            caps       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            gap        <= '0;
            ascii      <= '0;
            asciiready <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            lshift     <= (make | brk) && scan_byte == SC_LSHIFT ? make : lshift;
            rshift     <= (make | brk) && scan_byte == SC_RSHIFT ? make : rshift;
            caps_held  <= (make | brk) && scan_byte == SC_CAPS ? make : caps_held;
            caps       <= make && scan_byte == SC_CAPS && !caps_held ? !caps : caps;
            wr_ptr     <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
            cnt        <= cnt + CW'(do_push) - CW'(pop);
            gap        <= pop ? RELEASE_GAP - GAP_W'(1) : gap != '0 ? gap - GAP_W'(1) : gap;
            ascii      <= pop ? mem[rd_ptr] : ascii;
            asciiready <= pop;
            overflow   <= overflow | (push && full);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= map_ascii;
    end
endmodule

// File: tb/tb_ps2_ascii_source.sv
// tb_ps2_ascii_source: directed and random scancode streams against a queue-based keyboard model.
module tb_ps2_ascii_source;
    localparam int DEPTH = 4;
    localparam int GAP   = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_byte = 8'h00;
    logic [6:0] ascii;
    logic       asciiready, caps, overflow;

    ps2_ascii_source #(.FIFO_DEPTH(DEPTH), .GAP_W(24), .RELEASE_GAP(24'd4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .scan_byte  (scan_byte),
        .scan_valid (scan_valid),
        .ascii      (ascii),
        .asciiready (asciiready),
        .caps       (caps),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int obs_t[$];
    byte unsigned obs_c[$];

    byte unsigned q[$];
    bit m_ext, m_brk, m_ls, m_rs, m_held, m_caps, m_ovf, m_rdy;
    byte unsigned m_ascii;
    int m_gap;

    byte unsigned letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned digs[10]  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    byte unsigned punct[5]  = '{8'h4E, 8'h55, 8'h41, 8'h49, 8'h4A};
    byte unsigned pool[20]  = '{8'h1C, 8'h32, 8'h1A, 8'h15, 8'h16, 8'h45, 8'h3E, 8'h4E, 8'h4A, 8'h29,
                                8'h5A, 8'h66, 8'h12, 8'h59, 8'h58, 8'hE0, 8'hF0, 8'hF0, 8'h0E, 8'h75};
    string dp = "1234567890";
    string ds = "!@#$%^&*()";
    string pp = "-=,./";
    string ps = "_+<>?";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int map(byte unsigned c, bit sh, bit cp);
        foreach (letters[i]) if (letters[i] == c) return (sh ^ cp) ? 65 + i : 97 + i;
        foreach (digs[i]) if (digs[i] == c) return sh ? int'(ds[i]) : int'(dp[i]);
        foreach (punct[i]) if (punct[i] == c) return sh ? int'(ps[i]) : int'(pp[i]);
        if (c == 8'h29) return 32;
        if (c == 8'h5A) return 13;
        if (c == 8'h66) return 8;
        return -1;
    endfunction

    task automatic m_reset();
        {m_ext, m_brk, m_ls, m_rs, m_held, m_caps, m_ovf, m_rdy} = '0;
        m_ascii = 0;
        m_gap = 0;
        q.delete();
    endtask

    task automatic m_edge(input bit v, input byte unsigned b);
        bit pop, full;
        int c;
        c = -1;
        pop = m_gap == 0 && q.size() > 0;
        full = q.size() >= DEPTH;
        if (v) begin
            if (!m_ext && !m_brk) begin
                if (b == 8'hE0) m_ext = 1;
                else if (b == 8'hF0) m_brk = 1;
                else if (b == 8'h12) m_ls = 1;
                else if (b == 8'h59) m_rs = 1;
                else if (b == 8'h58) begin
                    if (!m_held) m_caps = !m_caps;
                    m_held = 1;
                end else c = map(b, m_ls | m_rs, m_caps);
            end else if (m_ext && !m_brk) begin
                if (b == 8'hF0) m_brk = 1;
                else m_ext = 0;
            end else if (m_ext) begin
                m_ext = 0;
                m_brk = 0;
            end else begin
                m_brk = 0;
                if (b == 8'h12) m_ls = 0;
                if (b == 8'h59) m_rs = 0;
                if (b == 8'h58) m_held = 0;
            end
        end
        m_rdy = pop;
        if (pop) m_ascii = q.pop_front();
        if (c >= 0) begin
            if (full) m_ovf = 1;
            else q.push_back(byte'(c));
        end
        if (pop) m_gap = GAP - 1;
        else if (m_gap > 0) m_gap--;
    endtask

    task automatic step(input bit v, input byte unsigned b);
        scan_valid = v;
        scan_byte = b;
        @(posedge clk);
        #1;
        cyc++;
        m_edge(v, b);
        check("asciiready", asciiready, m_rdy);
        check("ascii", ascii, m_ascii);
        check("caps", caps, m_caps);
        check("overflow", overflow, m_ovf);
        if (asciiready) begin
            obs_t.push_back(cyc);
            obs_c.push_back(ascii);
        end
    endtask

    task automatic send(input byte unsigned s[$]);
        foreach (s[i]) step(1'b1, s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic expect_chars(input string tag, input byte unsigned exp[$]);
        check({tag, "_count"}, obs_c.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs_c.size(); i++) check(tag, obs_c[i], exp[i]);
        obs_c.delete();
        obs_t.delete();
    endtask

    task automatic do_reset();
        scan_valid = 1'b0;
        resetn = 1'b0;
        #2;
        m_reset();
        check("rst_ascii", ascii, 0);
        check("rst_asciiready", asciiready, 0);
        check("rst_caps", caps, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk);
        #1;
        cyc++;
        resetn = 1'b1;
    endtask

    initial begin
        int n0;
        #1;
        do_reset();
        idle(3);
        obs_c.delete();
        obs_t.delete();

        n0 = cyc;
        send('{8'h1C});
        idle(8);
        check("latency", obs_t.size() > 0 ? obs_t[0] - n0 : -1, 2);
        expect_chars("make_a", '{8'h61});
        send('{8'hF0, 8'h1C});
        idle(8);
        expect_chars("break_a", '{});

        send('{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C});
        idle(12);
        expect_chars("shift", '{8'h41, 8'h61});

        send('{8'h58, 8'hF0, 8'h58, 8'h1C, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h1C});
        idle(12);
        check("caps_final", caps, 0);
        expect_chars("caps", '{8'h41, 8'h61});

        send('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h0E});
        idle(8);
        expect_chars("ext_unmapped", '{});
        send('{8'h66});
        idle(8);
        expect_chars("bs", '{8'h08});

        send('{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36});
        idle(24);
        check("burst_overflow", overflow, 1);
        for (int i = 1; i < obs_t.size(); i++) check("burst_spacing", obs_t[i] - obs_t[i-1], GAP);
        expect_chars("burst", '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35});

        send('{8'h16, 8'h1E, 8'h26, 8'hF0});
        do_reset();
        obs_c.delete();
        obs_t.delete();
        send('{8'h1C});
        idle(8);
        expect_chars("after_reset", '{8'h61});

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            else step($urandom_range(0, 99) < 45, pool[$urandom_range(0, 19)]);
        end
        for (int i = 0; i < 300; i++) step($urandom_range(0, 99) < 90, pool[$urandom_range(0, 11)]);
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_ascii_source.md
# ps2_ascii_source

Keystroke front end for the text/search datapath. It turns the byte stream from the PS/2 receiver (Set 2 scancodes) into 7-bit ASCII characters. It tracks make/break/extended prefixes, Shift and Caps Lock, buffers decoded characters in a small FIFO, and releases them as single-cycle `asciiready` pulses. Pulses are paced so that the search and edit consumers, which ignore input during their accept hold-off window, never miss a character.

## Interface
- `FIFO_DEPTH`, 4: character buffer entries (power of two, ≥2)
- `GAP_W`, 24: width of the release-gap counter
- `RELEASE_GAP`, 24'd8388608: minimum cycles between consecutive `asciiready` pulses (≥1)

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `scan_byte`  in  8  scancode byte from PS/2 receiver
- `scan_valid`  in  1  one-cycle strobe; `scan_byte` valid this cycle
- `ascii`  out  7  current character; held until next pulse; reset 0
- `asciiready`  out  1  one-cycle pulse, new `ascii` valid; reset 0
- `caps`  out  1  Caps Lock state (LED drive); reset 0
- `overflow`  out  1  sticky, set when a character is dropped on FIFO full; cleared only by reset; reset 0

## Operation
- Prefix FSM, advanced only on `scan_valid`:
  - IDLE: `E0` → EXT; `F0` → BRK; otherwise make-code processing, stay in IDLE.
  - BRK: break-code processing, → IDLE.
  - EXT: `F0` → EXT_BRK; any other byte is discarded, → IDLE.
  - EXT_BRK: byte discarded, → IDLE.
- Make processing:
  - `12`/`59` set `lshift`/`rshift`.
  - `58` toggles `caps` only if `caps_held`=0, then sets `caps_held`. Typematic repeats therefore do not re-toggle.
  - Any other byte is looked up. If it maps to a character, push it to the FIFO; if unmapped, drop it silently.
- Break processing: `12`/`59`/`58` clear `lshift`/`rshift`/`caps_held`; all other break codes are ignored.
- Mapping, with `shift` = `lshift|rshift`:
  - Letters `1C`..`1A` (a–z Set 2 codes): uppercase when `shift ^ caps`.
  - Digits `16 1E 26 25 2E 36 3D 3E 46 45`: give `1`..`0`, or `!@#$%^&*()` with `shift`.
  - `4E` gives `-`/`_`; `55` gives `=`/`+`; `41` gives `,`/`<`; `49` gives `.`/`>`; `4A` gives `/`/`?`.
  - `29` gives 32, `5A` gives 13, `66` gives 8. Shift and caps do not affect these three.
- Typematic repeat makes are pushed like fresh makes; pacing handles the rate.
- FIFO:
  - Push when full: drop the new character and set `overflow`.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Release: `gap` counter, reset 0.
  - When `gap`=0 and FIFO is non-empty: pop the head into `ascii`, assert `asciiready` for one cycle, load `gap`=`RELEASE_GAP`-1.
  - Otherwise decrement `gap` if nonzero.

## Timing
- Make code strobed in cycle N: FIFO write at the end of N; `asciiready`/`ascii` visible in cycle N+2 when `gap`=0 and the FIFO was empty. Latency is 2 cycles.
- Pulse spacing is exactly `RELEASE_GAP` cycles while the FIFO stays non-empty.
- Modifier updates take effect for a make code strobed in cycle N+1 or later. A letter following Shift-make by one strobe is shifted.
- Reset asserted mid-operation clears within the same cycle, asynchronously: FSM, FIFO, `gap`, modifiers, and all outputs. Any prefix in flight is lost.
- `scan_valid` on consecutive cycles is legal; every byte is consumed.

## Structure
- Shared package `kb_pkg`:
  - Scancode constants: `SC_EXT`=8'hE0, `SC_BRK`=8'hF0, `SC_LSHIFT`, `SC_RSHIFT`, `SC_CAPS`.
  - ASCII constants: `ASCII_CR`=13, `ASCII_BS`=8, `ASCII_SP`=32.
  - FSM state encoding.
- One combinational sub-module, `scancode_to_ascii`:
  - Inputs: `code[7:0]`, `shift`, `caps`.
  - Outputs: `ascii[6:0]`, `hit`.
- FSM, modifiers, FIFO and pacing live in the top module.

## Test plan
(`RELEASE_GAP`=4 unless noted.)
- `1C` → `asciiready` pulse 2 cycles after the strobe with `ascii`=7'h61; `F0 1C` produces no pulse.
- `12 1C F0 12 1C` → pulses `ascii`=7'h41 then 7'h61.
- `58 F0 58 1C 58 58 F0 58 1C` → `caps`=1, 7'h41, then `caps`=0 and 7'h61. The repeated `58` toggles only once.
- `E0 75`, `E0 F0 75`, `0E` (unmapped) → no pulses; a following `66` → `ascii`=8.
- Six makes `16 1E 26 25 2E 36` on consecutive cycles with `FIFO_DEPTH`=4 → first five characters `1 2 3 4 5` released (one pops during the burst), pulses exactly 4 cycles apart, `overflow`=1, `6` lost.
- Reset asserted between `F0` and `1C` with FIFO holding 2 characters → all outputs 0 immediately; after release, `1C` alone yields 7'h61.
